// File: rtl/saph_fpu_pkg.sv
// Shared types and constants for the FPU scheduler: opcodes, exception flag layout, owner tags.
package saph_fpu_pkg;

  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  // Wide enough for an owner index of up to 16 requesters
  localparam int unsigned OWNER_W = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_MIN  = 3'd4,
    OP_MAX  = 3'd5,
    OP_SQRT = 3'd6,
    OP_CMP  = 3'd7
  } fpu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } fpu_tag_t;

endpackage

// File: rtl/saph_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping, via a
// double-width masked lowest-set-bit search.
module saph_rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic          enable_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);
  localparam int unsigned W2 = 2 * N;

  logic [W2-1:0] req_dbl;
  logic [W2-1:0] keep;
  logic [W2-1:0] masked;
  logic [W2-1:0] first;

  // Lower copy keeps only indices >= ptr; upper copy supplies the wrapped-around ones
  assign req_dbl = {req_i, req_i};
  assign keep    = {{N{1'b1}}, ~((N'(1) << ptr_i) - N'(1))};
  assign masked  = req_dbl & keep;
  assign first   = masked & ~(masked - W2'(1));

  assign gnt_o = enable_i ? (first[N-1:0] | first[W2-1:N]) : '0;

  always_comb begin
    gnt_idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_o[i]) gnt_idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/saph_fpu_sched.sv
// Round-robin scheduler sharing one fixed-latency FPU unit between N_REQ requesters.
// Each issued op carries an owner tag down a LAT-deep pipe so its result returns to the issuer.
module saph_fpu_sched
  import saph_fpu_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned LAT       = 2,
  parameter bit          PIPELINED = 1'b1,
  parameter int unsigned OP_W      = 3,
  parameter int unsigned DW        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_op,
  input  logic [N_REQ*DW-1:0]   req_a,
  input  logic [N_REQ*DW-1:0]   req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic [FLAG_W-1:0]     rsp_flags,
  output logic                  fpu_valid,
  output logic [OP_W-1:0]       fpu_op,
  output logic [DW-1:0]         fpu_a,
  output logic [DW-1:0]         fpu_b,
  input  logic                  fpu_res_valid,
  input  logic [DW-1:0]         fpu_res,
  input  logic [FLAG_W-1:0]     fpu_res_flags,
  output logic                  err
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  fpu_tag_t          tag_q [LAT];
  fpu_tag_t          tag_d [LAT];
  fpu_tag_t          tail;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
  logic              err_q, err_d;

  logic              issue_en;
  logic              hs;
  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;

  // A non-pipelined unit only takes a new op once the previous result is back
  assign issue_en = PIPELINED || (state_q == ST_IDLE);

  saph_rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i     (req_valid),
    .enable_i  (issue_en),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign hs        = |gnt;
  assign req_ready = gnt;
  assign fpu_valid = hs;
  assign tail      = tag_q[LAT-1];

  always_comb begin
    fpu_op = '0;
    fpu_a  = '0;
    fpu_b  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        fpu_op = req_op[i*OP_W +: OP_W];
        fpu_a  = req_a[i*DW +: DW];
        fpu_b  = req_b[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs && !PIPELINED) state_d = ST_BUSY;
      ST_BUSY: if (fpu_res_valid)    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  always_comb begin
    tag_d[0].valid = hs;
    tag_d[0].owner = OWNER_W'(gnt_idx);
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tail tag and unit strobe must agree; any disagreement drops the tag and flags an error
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    err_d       = err_q;
    if (tail.valid && fpu_res_valid) begin
      rsp_valid_d = N_REQ'(1) << tail.owner;
      rsp_data_d  = fpu_res;
      rsp_flags_d = fpu_res_flags;
    end else if (tail.valid != fpu_res_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      err_q       <= err_d;
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign err       = err_q;

endmodule
